// File: rtl/cell_display_pipe.sv
// Raster-to-cell pixel pipeline: cell address out, state back after READ_LAT, palette colour,
// blinking cursor and optional cell grid (macro DISPLAY_GRID_EN). Syncs leave aligned with rgb.
module cell_display_pipe #(
  parameter int          COORD_BITS   = 11,
  parameter int          N_PX_BITS    = 4,
  parameter int          N_PY_BITS    = 4,
  parameter int          CELL_BITS    = 6,
  parameter int          STATE_BITS   = 2,
  parameter int          READ_LAT     = 1,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] GRID_COLOR   = 12'h444
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_BITS-1:0] x,
  input  logic [COORD_BITS-1:0] y,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic [N_PX_BITS-1:0]  x_array,
  output logic [N_PY_BITS-1:0]  y_array,
  input  logic [STATE_BITS-1:0] state,
  input  logic                  pal_we,
  input  logic [STATE_BITS-1:0] pal_addr,
  input  logic [11:0]           pal_data,
  input  logic                  cursor_en,
  input  logic [N_PX_BITS-1:0]  cursor_x,
  input  logic [N_PY_BITS-1:0]  cursor_y,
  output logic [11:0]           rgb,
  output logic                  hsync_out,
  output logic                  vsync_out
);
  localparam int XHI   = CELL_BITS + N_PX_BITS;
  localparam int YHI   = CELL_BITS + N_PY_BITS;
  localparam int PAL_N = 2**STATE_BITS;
  localparam int FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic oor;
    logic cur;
`ifdef DISPLAY_GRID_EN
    logic grid;
`endif
    logic hs;
    logic vs;
  } tag_t;

  tag_t                 tag0;
  tag_t [READ_LAT-1:0]  pipe_q;
  tag_t                 last;

  assign x_array = x[XHI-1:CELL_BITS];
  assign y_array = y[YHI-1:CELL_BITS];

`ifdef DISPLAY_GRID_EN
  logic grid0;
  assign grid0 = (x[CELL_BITS-1:0] == '0) || (y[CELL_BITS-1:0] == '0);
`else
  logic unused_lo;
  assign unused_lo = ^{x[CELL_BITS-1:0], y[CELL_BITS-1:0]};
`endif

  always_comb begin
    tag0     = '0;
    tag0.oor = (|x[COORD_BITS-1:XHI]) | (|y[COORD_BITS-1:YHI]);
    tag0.cur = cursor_en && (x_array == cursor_x) && (y_array == cursor_y);
`ifdef DISPLAY_GRID_EN
    tag0.grid = grid0;
`endif
    tag0.hs  = hsync_in;
    tag0.vs  = vsync_in;
  end

  // pixel flags travel alongside the outstanding state-memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag0;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign last = pipe_q[READ_LAT-1];

  logic [11:0] pal_q [PAL_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  logic           vs_q, vs_rise;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_on_q, blink_on_d;

  assign vs_rise = vsync_in & ~vs_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (vs_rise) begin
      if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      vs_q        <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  logic [11:0] pix, rgb_d, rgb_q;
  logic        hs_q, vs_out_q;

  // priority: out of range, then grid, then palette with cursor inversion
  always_comb begin
    pix = pal_q[state];
    if (last.cur && blink_on_q) pix = pix ^ 12'hFFF;
    rgb_d = pix;
`ifdef DISPLAY_GRID_EN
    if (last.grid) rgb_d = GRID_COLOR;
`endif
    if (last.oor) rgb_d = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= '0;
      hs_q     <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hs_q     <= last.hs;
      vs_out_q <= last.vs;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_out_q;
endmodule

// File: doc/cell_display_pipe.md
# cell_display_pipe

Pipelined pixel renderer between the VGA timing generator and the video output pins. It converts the raster position into a PE-array cell address and waits a configurable number of cycles for the cell state to return from the state memory. It then colours the pixel through a writable palette, with a blinking cursor overlay and an optional cell grid. Sync signals are delayed to match the pixel path, so rgb, hsync and vsync leave the block aligned.

## Interface
Parameters:
- COORD_BITS, 11, width of raster x/y.
- N_PX_BITS, 4, log2 of array columns.
- N_PY_BITS, 4, log2 of array rows.
- CELL_BITS, 6, log2 of cell edge in pixels (64 px cells).
- STATE_BITS, 2, width of PE state; palette has 2**STATE_BITS entries.
- READ_LAT, 1, state-memory read latency in cycles; legal range 1..3.
- BLINK_FRAMES, 30, frames per cursor blink half-period; must be ≥1.
- GRID_COLOR, 12'h444, grid line colour.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- x, input, COORD_BITS, raster column.
- y, input, COORD_BITS, raster row.
- hsync_in, input, 1, horizontal sync aligned with x/y.
- vsync_in, input, 1, vertical sync aligned with x/y (active-high).
- x_array, output, N_PX_BITS, cell column = x[CELL_BITS+N_PX_BITS-1:CELL_BITS]; combinational.
- y_array, output, N_PY_BITS, cell row = y[CELL_BITS+N_PY_BITS-1:CELL_BITS]; combinational.
- state, input, STATE_BITS, cell state, valid READ_LAT cycles after x_array/y_array.
- pal_we, input, 1, palette write strobe.
- pal_addr, input, STATE_BITS, palette entry.
- pal_data, input, 12, RGB444 value.
- cursor_en, input, 1, cursor overlay enable.
- cursor_x, input, N_PX_BITS, cursor cell column.
- cursor_y, input, N_PY_BITS, cursor cell row.
- rgb, output, 12, registered pixel colour.
- hsync_out, output, 1, hsync_in delayed READ_LAT+1 cycles.
- vsync_out, output, 1, vsync_in delayed READ_LAT+1 cycles.

## Operation
- Stage 0 (combinational) computes:
  - the address outputs;
  - oor = any x or y bit at position ≥ CELL_BITS+N_PX_BITS (resp. N_PY_BITS) set;
  - cur_hit = cursor_en && cell == (cursor_x, cursor_y);
  - grid = x[CELL_BITS-1:0]==0 || y[CELL_BITS-1:0]==0.
- oor, cur_hit, grid, hsync and vsync pass through a READ_LAT-deep shift register.
- At the last stage, colour is chosen by the first matching rule, in this order:
  1. oor → 12'h000.
  2. grid (config) → GRID_COLOR.
  3. Otherwise → pal[state]; XOR 12'hFFF when cur_hit && blink_on.
- The chosen colour is registered into rgb.
- Palette: a register file written on a clk edge when pal_we=1. A lookup in the same cycle as a write to the same entry returns the old value; the new value is used from the next cycle.
- Blink engine:
  - vsync rising edge is detected against a registered copy of vsync_in.
  - On each rising edge, frame_cnt increments.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_on.
- Reset values, applied on the first clk edge with rst=1:
  - rgb=0, hsync_out=0, vsync_out=0;
  - all delay stages 0, frame_cnt=0, blink_on=1;
  - pal[0]=12'h000, all other entries 12'hFFF.
- Reset mid-frame flushes the pipeline. Outputs stay 0 while rst is high. Valid output resumes READ_LAT+1 cycles after rst deasserts.
- pal_we is ignored while rst=1.

## Timing
- Latency from x/y/sync to rgb/sync_out is exactly READ_LAT+1 cycles, fixed and independent of all modes.
- Throughput is one pixel per cycle; there is no stall or backpressure.
- cursor_* and cursor_en are sampled at stage 0 with the pixel they apply to. A change mid-frame affects pixels from that cycle on.
- blink_on changes one cycle after the vsync_in rising edge.

## Configuration
- Macro DISPLAY_GRID_EN.
- Defined: rule 2 is active; the first pixel row and column of every in-range cell render GRID_COLOR, and the cursor does not invert grid pixels.
- Undefined: the grid flag is not built (no delay-line bit) and cells render edge to edge in palette colour.

## Test plan
- Reset with defaults, sweep x=0..1023 on y=65 with state=1 → rgb=12'hFFF after 2 cycles, hsync_out mirrors hsync_in delayed 2 cycles. With DISPLAY_GRID_EN, x multiples of 64 give 12'h444.
- x=1024, state=1 → rgb=12'h000 (out of range); x=1023,y=1023 → x_array=15, y_array=15.
- Write pal[2]=12'hF00, then in the same cycle present state=2 → first pixel shows the old 12'hFFF, the following pixel shows 12'hF00.
- BLINK_FRAMES=2, cursor at (3,5) with cursor_en=1, state=0:
  - frames 0–1 → cursor cell pixels 12'hFFF;
  - frames 2–3 → 12'h000;
  - other cells always 12'h000.
- READ_LAT=3 → rgb and sync outputs lag input by 4 cycles; state is sampled 3 cycles after the address.
- Assert rst for 1 cycle mid-line → next cycle rgb=0 and syncs=0, and the palette returns to defaults (pal[2] reads 12'hFFF).
